// File: rtl/pc_fetch.sv
// Program counter and instruction fetch unit for the picoMIPS core.
// Fetches one word over req/ack and presents it to decode over valid/ready.
//
// state | meaning
// IDLE  | reset / one settling cycle before the first fetch
// FETCH | imem_req high at address pc, waiting for imem_ack
// HOLD  | instr valid at pc, waiting for instr_ready to retire it
module pc_fetch #(
   parameter int PSIZE = 6,
   parameter int ISIZE = 20,
   parameter int OFF_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pc_incr,
   input  logic             pc_relbranch,
   input  logic [OFF_W-1:0] branch_offset,
   output logic             imem_req,
   output logic [PSIZE-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [ISIZE-1:0] imem_rdata,
   output logic [ISIZE-1:0] instr,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic [PSIZE-1:0] pc
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int EXT_W = (OFF_W > PSIZE) ? OFF_W : PSIZE;

   state_t           state;
   logic [EXT_W-1:0] off_ext;
   logic [PSIZE-1:0] pc_next;

   // Relative branch wraps modulo 2^PSIZE in both directions.
   assign off_ext = EXT_W'($signed(branch_offset));

   always_comb begin
      pc_next = pc;
      if (pc_relbranch)
         pc_next = PSIZE'(EXT_W'(pc) + off_ext);
      else if (pc_incr)
         pc_next = pc + PSIZE'(1);
   end

   assign imem_addr = pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= '0;
         instr       <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state    <= FETCH;
               imem_req <= 1'b1;
            end
            FETCH: begin
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  state       <= HOLD;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  pc          <= pc_next;
                  state       <= FETCH;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: bench-side memory responder, PC model and
// a queue of expected (pc, instr) pairs consumed as instructions appear.
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_incr;
   logic        pc_relbranch;
   logic [7:0]  branch_offset;
   logic        imem_req;
   logic [5:0]  imem_addr;
   logic        imem_ack;
   logic [19:0] imem_rdata;
   logic [19:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [5:0]  pc;

   typedef struct {
      logic [5:0]  pc;
      logic [19:0] instr;
   } exp_t;

   exp_t       sb[$];
   exp_t       cur;
   logic [5:0] model_pc;
   int         checks = 0;
   int         errors = 0;

   pc_fetch #(.PSIZE(6), .ISIZE(20), .OFF_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .pc_incr       (pc_incr),
      .pc_relbranch  (pc_relbranch),
      .branch_offset (branch_offset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .pc            (pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_expected();
      exp_t e;
      e.pc    = model_pc;
      e.instr = 20'h100 + 20'(model_pc);
      sb.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   imem_req,    1'b0);
      check({tag, "_valid"}, instr_valid, 1'b0);
      check({tag, "_instr"}, instr,       20'h0);
      check({tag, "_pc"},    pc,          6'd0);
      check({tag, "_addr"},  imem_addr,   6'd0);
   endtask

   // Waits (bounded) for a request, serves it after dly wait states.
   task automatic fetch(input int dly);
      int         n;
      logic [5:0] a;
      exp_t       e;
      n = 0;
      while (imem_req !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      check("req_seen", imem_req, 1'b1);
      check("fetch_addr", imem_addr, model_pc);
      a = imem_addr;
      for (int i = 0; i < dly; i++) begin
         imem_ack   = 1'b0;
         imem_rdata = 20'($urandom);
         step();
         check("wait_req", imem_req, 1'b1);
         check("wait_addr", imem_addr, a);
         check("wait_valid", instr_valid, 1'b0);
      end
      imem_ack   = 1'b1;
      imem_rdata = 20'h100 + 20'(a);
      step();
      imem_ack   = 1'b0;
      imem_rdata = 20'($urandom);
      check("valid_rise", instr_valid, 1'b1);
      check("req_drop", imem_req, 1'b0);
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL sb_empty: observed instr 0x%0h with no expected entry", instr);
      end else begin
         e = sb.pop_front();
         check("instr", instr, e.instr);
         check("pc", pc, e.pc);
         cur = e;
      end
   endtask

   // Stalls in HOLD with garbage inputs, then retires with the given controls.
   task automatic retire(input logic inc, input logic rel, input logic [7:0] off, input int stall);
      int o;
      for (int i = 0; i < stall; i++) begin
         instr_ready   = 1'b0;
         imem_ack      = 1'($urandom);
         imem_rdata    = 20'($urandom);
         pc_incr       = 1'($urandom);
         pc_relbranch  = 1'($urandom);
         branch_offset = 8'($urandom);
         step();
         check("stall_instr", instr, cur.instr);
         check("stall_pc", pc, cur.pc);
         check("stall_valid", instr_valid, 1'b1);
         check("stall_req", imem_req, 1'b0);
      end
      imem_ack      = 1'b0;
      instr_ready   = 1'b1;
      pc_incr       = inc;
      pc_relbranch  = rel;
      branch_offset = off;
      o = int'($signed(off));
      if (rel)
         model_pc = 6'((int'(model_pc) + o) & 63);
      else if (inc)
         model_pc = model_pc + 6'd1;
      push_expected();
      step();
      instr_ready   = 1'b0;
      pc_incr       = 1'($urandom);
      pc_relbranch  = 1'($urandom);
      branch_offset = 8'($urandom);
      check("retire_valid", instr_valid, 1'b0);
      check("retire_req", imem_req, 1'b1);
      check("retire_addr", imem_addr, model_pc);
   endtask

   initial begin
      reset         = 1'b1;
      pc_incr       = 1'b1;
      pc_relbranch  = 1'b0;
      branch_offset = 8'h0;
      imem_ack      = 1'b1;
      imem_rdata    = 20'hDEAD0;
      instr_ready   = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst");
      step();
      check_reset_outputs("rst2");

      // Release: one IDLE cycle (ack ignored), then request.
      reset = 1'b0;
      #1;
      check("idle_req", imem_req, 1'b0);
      @(negedge clk);
      imem_ack = 1'b0;
      check("idle_valid", instr_valid, 1'b0);
      check("idle_instr", instr, 20'h0);
      step();
      check("first_req", imem_req, 1'b1);
      instr_ready = 1'b0;

      model_pc = 6'd0;
      push_expected();
      fetch(0); retire(1'b1, 1'b0, 8'h00, 0);
      fetch(0); retire(1'b1, 1'b0, 8'h00, 0);
      fetch(0); retire(1'b1, 1'b0, 8'h00, 0);
      fetch(3); retire(1'b1, 1'b0, 8'h00, 0);
      fetch(1); retire(1'b1, 1'b0, 8'h00, 0);
      fetch(0); retire(1'b0, 1'b1, 8'hFE, 0);   // 5 -> 3
      fetch(2); retire(1'b0, 1'b1, 8'd10, 0);   // 3 -> 13
      fetch(0); retire(1'b0, 1'b1, 8'd50, 0);   // 13 -> 63
      fetch(0); retire(1'b1, 1'b0, 8'h00, 0);   // 63 -> 0
      fetch(0); retire(1'b0, 1'b1, 8'd2, 0);    // 0 -> 2
      fetch(0); retire(1'b0, 1'b1, 8'hFC, 0);   // 2 -> 62
      fetch(0); retire(1'b0, 1'b1, 8'd9, 0);    // 62 -> 7
      for (int k = 0; k < 3; k++) begin
         fetch(0);
         retire(1'b0, 1'b0, 8'h00, 0);          // spin at 7
      end
      fetch(0); retire(1'b1, 1'b0, 8'h00, 4);   // stall, 7 -> 8
      fetch(1); retire(1'b1, 1'b1, 8'd3, 0);    // branch wins, 8 -> 11
      fetch(0); retire(1'b1, 1'b0, 8'h00, 0);   // 11 -> 12, now in FETCH

      // Abort the pending fetch with a one-cycle reset and a stale ack.
      check("pre_abort_req", imem_req, 1'b1);
      reset = 1'b1;
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      reset      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 20'hABCDE;
      step();
      imem_ack = 1'b0;
      check("stale_valid", instr_valid, 1'b0);
      check("stale_instr", instr, 20'h0);
      check("restart_req", imem_req, 1'b1);
      check("restart_addr", imem_addr, 6'd0);
      sb.delete();
      model_pc = 6'd0;
      push_expected();
      fetch(0); retire(1'b1, 1'b0, 8'h00, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
